// File: rtl/genius_control.sv
// Genius (Simon) game sequencer: builds an LFSR colour sequence, plays it through the
// interval timer and checks the player's presses. Optional macro GENIUS_ECHO_EN echoes presses on LEDS.
module genius_control #(
    parameter int          SEQ_LEN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         CLKT,
    input  logic                         R,
    input  logic                         START,
    input  logic [3:0]                   BTN,
    input  logic                         end_time,
    output logic                         E_TIME,
    output logic                         R_TIME,
    output logic [3:0]                   LEDS,
    output logic [$clog2(SEQ_LEN+1)-1:0] ROUND,
    output logic                         WIN,
    output logic                         LOSE,
    output logic [2:0]                   state_dbg
);

    localparam int RW = $clog2(SEQ_LEN + 1);
    localparam int IW = $clog2(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [1:0]  seq [SEQ_LEN];
    logic [IW-1:0] gen_cnt;
    logic [IW-1:0] idx;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    logic [IW-1:0] idx_inc;
    logic [3:0]    cur_color;
    logic [3:0]    next_color;
    logic [3:0]    first_color;
    logic          last_step;
    logic          last_round;
    logic          expiry;
    logic          press;
    logic          press_ok;
    logic [3:0]    echo;

    assign idx_inc     = idx + IW'(1);
    assign cur_color   = onehot(seq[idx]);
    assign next_color  = onehot(seq[idx_inc]);
    assign first_color = onehot(seq[0]);
    assign last_step   = (RW'(idx) + RW'(1)) == ROUND;
    assign last_round  = ROUND == RW'(SEQ_LEN);
    // The timer is being cleared while R_TIME is high, so any expiry seen then is stale.
    assign expiry      = end_time && !R_TIME;
    assign press       = |BTN;
    assign press_ok    = BTN == cur_color;
    assign state_dbg   = state;

`ifdef GENIUS_ECHO_EN
    assign echo = BTN;
`else
    assign echo = 4'b0000;
`endif

    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Sequence store needs no reset: GEN rewrites every entry before it is read.
    always_ff @(posedge CLKT) begin
        if (state == S_GEN) begin
            seq[gen_cnt] <= lfsr[1:0];
        end
    end

    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            state   <= S_IDLE;
            gen_cnt <= '0;
            idx     <= '0;
            ROUND   <= '0;
            LEDS    <= 4'b0000;
            WIN     <= 1'b0;
            LOSE    <= 1'b0;
            E_TIME  <= 1'b0;
            R_TIME  <= 1'b0;
        end else begin
            R_TIME <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_GEN;
                        gen_cnt <= '0;
                    end
                end
                S_GEN: begin
                    gen_cnt <= gen_cnt + IW'(1);
                    if (gen_cnt == IW'(SEQ_LEN - 1)) begin
                        state  <= S_SHOW_ON;
                        idx    <= '0;
                        ROUND  <= RW'(1);
                        LEDS   <= first_color;
                        E_TIME <= 1'b1;
                        R_TIME <= 1'b1;
                    end
                end
                S_SHOW_ON: begin
                    if (expiry) begin
                        state  <= S_SHOW_OFF;
                        LEDS   <= 4'b0000;
                        R_TIME <= 1'b1;
                    end
                end
                S_SHOW_OFF: begin
                    if (expiry) begin
                        R_TIME <= 1'b1;
                        if (last_step) begin
                            idx   <= '0;
                            state <= S_WAIT_IN;
                        end else begin
                            idx   <= idx_inc;
                            state <= S_SHOW_ON;
                            LEDS  <= next_color;
                        end
                    end
                end
                S_WAIT_IN: begin
                    LEDS <= echo;
                    if (press) begin
                        if (press_ok) begin
                            R_TIME <= 1'b1;
                            if (last_step) begin
                                idx <= '0;
                                if (last_round) begin
                                    state  <= S_WIN;
                                    WIN    <= 1'b1;
                                    E_TIME <= 1'b0;
                                end else begin
                                    // Replay display wins over the echo on a round change.
                                    ROUND <= ROUND + RW'(1);
                                    state <= S_SHOW_ON;
                                    LEDS  <= first_color;
                                end
                            end else begin
                                idx <= idx_inc;
                            end
                        end else begin
                            state  <= S_LOSE;
                            LOSE   <= 1'b1;
                            E_TIME <= 1'b0;
                        end
                    end else if (expiry) begin
                        state  <= S_LOSE;
                        LOSE   <= 1'b1;
                        E_TIME <= 1'b0;
                    end
                end
                S_WIN, S_LOSE: begin
                    LEDS <= 4'b0000;
                    if (START) begin
                        state   <= S_GEN;
                        gen_cnt <= '0;
                        ROUND   <= '0;
                        WIN     <= 1'b0;
                        LOSE    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
